// File: rtl/display_serial_receiver.sv
// Three-wire display bus deserializer: synchronizes data/latch/clock, shifts one bit per
// serial-clock rise and publishes the frame on latch rise. Option macro: DISPLAY_RX_GLITCH_FILTER_EN.
module display_serial_receiver #(
  parameter int FRAME_BITS  = 48,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                i_clk,
  input  logic                                i_reset_n,
  input  logic                                i_en,
  input  logic                                i_serial_data,
  input  logic                                i_serial_latch,
  input  logic                                i_serial_clk,
  output logic [FRAME_BITS-1:0]               o_frame,
  output logic                                o_frame_valid,
  output logic                                o_frame_error,
  output logic [$clog2(FRAME_BITS+2)-1:0]     o_bit_count
);

  localparam int CW = $clog2(FRAME_BITS + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_OVER = CW'(FRAME_BITS + 1);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  // Lines are packed {data, latch, clk} so all three see identical delay.
  logic [SYNC_STAGES-1:0] r_sync_data, r_sync_latch, r_sync_clk;
  logic [2:0]             w_sync;
  logic [2:0]             w_line;
  logic [2:0]             r_prev;
  logic                   r_clk_rise, r_latch_rise, r_data_q;

  state_t                 r_state, w_state_nxt;
  logic [FRAME_BITS-1:0]  r_sr, w_sr_nxt, w_sr_shifted, w_frame_nxt;
  logic [CW-1:0]          r_count, w_count_nxt;
  logic                   w_valid_nxt, w_error_nxt;

  // NOTE: every flop here, including the synchronizers, is reset so a mid-frame reset leaves no residue.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync_data  <= '0;
      r_sync_latch <= '0;
      r_sync_clk   <= '0;
    end else begin
      // NOTE: non-blocking assignments let each stage capture the previous stage's old value.
      r_sync_data  <= {r_sync_data[SYNC_STAGES-2:0],  i_serial_data};
      r_sync_latch <= {r_sync_latch[SYNC_STAGES-2:0], i_serial_latch};
      r_sync_clk   <= {r_sync_clk[SYNC_STAGES-2:0],   i_serial_clk};
    end
  end

  assign w_sync = {r_sync_data[SYNC_STAGES-1], r_sync_latch[SYNC_STAGES-1], r_sync_clk[SYNC_STAGES-1]};

`ifdef DISPLAY_RX_GLITCH_FILTER_EN
  // Output follows a line only after two consecutive agreeing samples.
  logic [2:0] r_filt_last, r_filt;
  logic [2:0] w_agree;

  assign w_agree = ~(w_sync ^ r_filt_last);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_filt_last <= '0;
      r_filt      <= '0;
    end else begin
      r_filt_last <= w_sync;
      r_filt      <= (w_agree & w_sync) | (~w_agree & r_filt);
    end
  end

  assign w_line = r_filt;
`else
  assign w_line = w_sync;
`endif

  // Edge pulses are registered together with the data bit to keep them aligned.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_prev       <= '0;
      r_clk_rise   <= 1'b0;
      r_latch_rise <= 1'b0;
      r_data_q     <= 1'b0;
    end else begin
      r_prev       <= w_line;
      r_clk_rise   <= i_en & w_line[0] & ~r_prev[0];
      r_latch_rise <= i_en & w_line[1] & ~r_prev[1];
      r_data_q     <= w_line[2];
    end
  end

  generate
    if (MSB_FIRST) begin : g_msb
      assign w_sr_shifted = {r_sr[FRAME_BITS-2:0], r_data_q};
    end else begin : g_lsb
      assign w_sr_shifted = {r_data_q, r_sr[FRAME_BITS-1:1]};
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= ST_IDLE;
      r_sr          <= '0;
      r_count       <= '0;
      o_frame       <= '0;
      o_frame_valid <= 1'b0;
      o_frame_error <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_sr          <= w_sr_nxt;
      r_count       <= w_count_nxt;
      o_frame       <= w_frame_nxt;
      o_frame_valid <= w_valid_nxt;
      o_frame_error <= w_error_nxt;
    end
  end

  // Shift is applied first; a coincident latch then judges the post-shift count and register.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_count_nxt = r_count;
    w_frame_nxt = o_frame;
    w_valid_nxt = 1'b0;
    w_error_nxt = 1'b0;

    if (!i_en) begin
      w_state_nxt = ST_IDLE;
      w_count_nxt = '0;
    end else begin
      if (r_clk_rise) begin
        w_sr_nxt    = w_sr_shifted;
        w_state_nxt = ST_SHIFT;
        if (r_state == ST_IDLE) begin
          w_count_nxt = CW'(1);
        end else if (r_count != CNT_OVER) begin
          w_count_nxt = r_count + CW'(1);
        end
      end
      if (r_latch_rise) begin
        if (w_count_nxt == CNT_FULL) begin
          w_frame_nxt = w_sr_nxt;
          w_valid_nxt = 1'b1;
        end else begin
          w_error_nxt = 1'b1;
        end
        w_count_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
    end
  end

  assign o_bit_count = r_count;

endmodule

// File: tb/tb_display_serial_receiver.sv
// Scoreboard bench: stimulus pushes expected frame events, monitors pop and compare on each pulse.
module tb_display_serial_receiver;

  localparam int FB = 48;

  typedef struct {
    bit          is_error;
    logic [FB-1:0] frame;
  } exp_t;

  logic clk, rst_n, en;
  logic sd0, sl0, sc0, sd1, sl1, sc1;
  logic [FB-1:0] frame0, frame1;
  logic valid0, valid1, err0, err1;
  logic [5:0] cnt0, cnt1;

  int checks   = 0;
  int failures = 0;
  int sel      = 0;
  logic [FB-1:0] exp_frame0 = '0;
  exp_t q0[$];
  exp_t q1[$];

  display_serial_receiver #(.FRAME_BITS(FB), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) u_dut_msb (
    .i_clk(clk), .i_reset_n(rst_n), .i_en(en),
    .i_serial_data(sd0), .i_serial_latch(sl0), .i_serial_clk(sc0),
    .o_frame(frame0), .o_frame_valid(valid0), .o_frame_error(err0), .o_bit_count(cnt0)
  );

  display_serial_receiver #(.FRAME_BITS(FB), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) u_dut_lsb (
    .i_clk(clk), .i_reset_n(rst_n), .i_en(en),
    .i_serial_data(sd1), .i_serial_latch(sl1), .i_serial_clk(sc1),
    .o_frame(frame1), .o_frame_valid(valid1), .o_frame_error(err1), .o_bit_count(cnt1)
  );

  initial clk = 1'b0;
  always #100 clk = ~clk;  // 5 MHz

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic push0(input bit is_err, input logic [FB-1:0] f);
    exp_t e;
    e.is_error = is_err;
    e.frame    = f;
    q0.push_back(e);
  endtask

  // Scoreboard monitor for each receiver.
  always @(negedge clk) begin
    if (rst_n && (valid0 || err0)) begin
      if (valid0 && err0) check("msb_valid_and_error", 1, 0);
      if (q0.size() == 0) begin
        check("msb_unexpected_pulse", {valid0, err0}, 0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        check("msb_pulse_kind", err0, e.is_error);
        check("msb_frame", frame0, e.frame);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && (valid1 || err1)) begin
      if (q1.size() == 0) begin
        check("lsb_unexpected_pulse", {valid1, err1}, 0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("lsb_pulse_kind", err1, e.is_error);
        check("lsb_frame", frame1, e.frame);
      end
    end
  end

  task automatic drive(input logic d, input logic c, input logic l);
    if (sel == 0) begin sd0 = d; sc0 = c; sl0 = l; end
    else          begin sd1 = d; sc1 = c; sl1 = l; end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // 6-cycle bit: data changes with the falling clock, 3 cycles low then 3 high.
  task automatic send_bit(input logic b);
    drive(b, 1'b0, 1'b0);
    wait_cycles(3);
    drive(b, 1'b1, 1'b0);
    wait_cycles(3);
    drive(b, 1'b0, 1'b0);
  endtask

  task automatic send_bits(input logic [63:0] v, input int n, input bit msb);
    for (int i = 0; i < n; i++) send_bit(msb ? v[n-1-i] : v[i]);
    wait_cycles(6);
  endtask

  task automatic latch_pulse();
    drive(1'b0, 1'b0, 1'b1);
    wait_cycles(3);
    drive(1'b0, 1'b0, 1'b0);
    wait_cycles(8);
  endtask

  initial begin
    logic [63:0] v;
    rst_n = 1'b0; en = 1'b1;
    sd0 = 0; sl0 = 0; sc0 = 0; sd1 = 0; sl1 = 0; sc1 = 0;
    wait_cycles(4);
    check("reset_frame", frame0, 0);
    check("reset_valid", valid0, 0);
    check("reset_error", err0, 0);
    check("reset_count", cnt0, 0);
    rst_n = 1'b1;
    wait_cycles(4);

    // Full frame.
    v = 64'hA53C0FF0817E;
    send_bits(v, 48, 1'b1);
    check("count_full", cnt0, 48);
    push0(1'b0, 48'hA53C0FF0817E);
    exp_frame0 = 48'hA53C0FF0817E;
    latch_pulse();
    check("count_after_latch", cnt0, 0);

    // Short frame: error, frame held.
    v = 64'h123456789ABC;
    send_bits(v, 47, 1'b1);
    check("count_short", cnt0, 47);
    push0(1'b1, exp_frame0);
    latch_pulse();

    // Long frame: count reads 49, error.
    send_bits(v, 49, 1'b1);
    check("count_long", cnt0, 49);
    push0(1'b1, exp_frame0);
    latch_pulse();
    check("frame_held_after_errors", frame0, 48'hA53C0FF0817E);

    // Reset mid-frame, then a clean frame.
    send_bits(v, 20, 1'b1);
    check("count_partial", cnt0, 20);
    rst_n = 1'b0;
    wait_cycles(3);
    rst_n = 1'b1;
    exp_frame0 = '0;
    wait_cycles(4);
    check("count_after_reset", cnt0, 0);
    check("frame_after_reset", frame0, 0);
    send_bits(v, 48, 1'b1);
    push0(1'b0, 48'h123456789ABC);
    exp_frame0 = 48'h123456789ABC;
    latch_pulse();

    // Disabled: everything ignored.
    en = 1'b0;
    v = 64'hFFFF0000FFFF;
    send_bits(v, 48, 1'b1);
    check("count_disabled", cnt0, 0);
    latch_pulse();
    check("frame_disabled", frame0, 48'h123456789ABC);
    en = 1'b1;
    wait_cycles(4);
    v = 64'hDEADBEEFCAFE;
    send_bits(v, 48, 1'b1);
    push0(1'b0, 48'hDEADBEEFCAFE);
    exp_frame0 = 48'hDEADBEEFCAFE;
    latch_pulse();

    // Clock and latch rise together on the 48th bit.
    v = 64'h0F0F00FF1235;
    send_bits(v >> 1, 47, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    wait_cycles(3);
    drive(1'b1, 1'b1, 1'b1);
    wait_cycles(3);
    drive(1'b0, 1'b0, 1'b0);
    push0(1'b0, 48'h0F0F00FF1235);
    exp_frame0 = 48'h0F0F00FF1235;
    wait_cycles(10);
    check("count_after_simultaneous", cnt0, 0);

    // Single-cycle glitch on the serial clock mid-frame.
    v = 64'h5A5A5A5A5A5A;
    send_bits(v >> 24, 24, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    wait_cycles(1);
    drive(1'b0, 1'b0, 1'b0);
    wait_cycles(3);
    send_bits(v, 24, 1'b1);
`ifdef DISPLAY_RX_GLITCH_FILTER_EN
    check("count_glitch", cnt0, 48);
    push0(1'b0, 48'h5A5A5A5A5A5A);
`else
    check("count_glitch", cnt0, 49);
    push0(1'b1, exp_frame0);
`endif
    latch_pulse();

    // LSB-first receiver.
    sel = 1;
    begin
      exp_t e;
      e.is_error = 1'b0;
      e.frame    = 48'h000000000001;
      q1.push_back(e);
    end
    v = 64'h000000000001;
    send_bits(v, 48, 1'b0);
    check("lsb_count_full", cnt1, 48);
    latch_pulse();
    check("lsb_count_after_latch", cnt1, 0);

    wait_cycles(10);
    check("msb_queue_drained", q0.size(), 0);
    check("lsb_queue_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
